// File: rtl/can_bus_responder.sv
// Controller-side responder for the 8-bit multiplexed Intel-mode CAN bus.
// Latches address on ALE, serves reads, commits writes, drives INT_n.
module can_bus_responder #(
  parameter int         ADDR_W      = 5,
  parameter int         SYNC_STAGES = 2,
  parameter int         IR_ADDR     = 3,
  parameter int         IER_ADDR    = 4,
  parameter logic [7:0] MODE_RST    = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_ad_i,
  output logic [7:0] bus_ad_o,
  output logic       bus_ad_oe,
  input  logic       bus_ale,
  input  logic       bus_cs_n,
  input  logic       bus_rd_n,
  input  logic       bus_wr_n,
  input  logic       bus_rst_n,
  output logic       bus_int_n,
  input  logic [7:0] evt_i,
  output logic       wr_evt_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] mode_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SEL,
    RD,
    WR
  } state_t;

  localparam int NREG = 1 << ADDR_W;
  localparam int SW   = 13;
  localparam logic [7:0] IR_A = 8'(IR_ADDR);
  localparam logic [8:0] NREG9 = 9'(NREG);
  // bundle order: ale, cs_n, rd_n, wr_n, rst_n, ad
  localparam logic [SW-1:0] SYNC_IDLE =
    {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};

  logic [SW-1:0] sync_q [SYNC_STAGES];

  logic       ale_s;
  logic       cs_n_s;
  logic       rd_n_s;
  logic       wr_n_s;
  logic       rst_n_s;
  logic [7:0] ad_s;

  logic ale_p;
  logic cs_n_p;
  logic rd_n_p;
  logic wr_n_p;

  state_t state_q;
  state_t state_d;

  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] regs [NREG];

  logic       latch_addr;
  logic       rd_load;
  logic       rd_exit;
  logic       wr_cap;
  logic       wr_commit;
  logic       in_range;
  logic [7:0] rdata;
  logic [7:0] ir_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
    end else begin
      sync_q[0] <= {bus_ale, bus_cs_n, bus_rd_n,
                    bus_wr_n, bus_rst_n, bus_ad_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign {ale_s, cs_n_s, rd_n_s, wr_n_s, rst_n_s, ad_s} =
    sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ale_p  <= 1'b0;
      cs_n_p <= 1'b1;
      rd_n_p <= 1'b1;
      wr_n_p <= 1'b1;
    end else begin
      ale_p  <= ale_s;
      cs_n_p <= cs_n_s;
      rd_n_p <= rd_n_s;
      wr_n_p <= wr_n_s;
    end
  end

  logic ale_rise;
  logic ale_fall;
  logic cs_rise;
  logic rd_fall;
  logic rd_rise;
  logic wr_fall;
  logic wr_rise;

  assign ale_rise = ale_s & ~ale_p;
  assign ale_fall = ~ale_s & ale_p;
  assign cs_rise  = cs_n_s & ~cs_n_p;
  assign rd_fall  = ~rd_n_s & rd_n_p;
  assign rd_rise  = rd_n_s & ~rd_n_p;
  assign wr_fall  = ~wr_n_s & wr_n_p;
  assign wr_rise  = wr_n_s & ~wr_n_p;

  assign in_range = {1'b0, addr_q} < NREG9;
  assign rdata    = in_range ? regs[addr_q[ADDR_W-1:0]]
                             : 8'hFF;
  assign mode_o   = regs[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    rd_load    = 1'b0;
    rd_exit    = 1'b0;
    wr_cap     = 1'b0;
    wr_commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ale_rise) state_d = ADDR;
      end
      ADDR: begin
        if (ale_fall) begin
          latch_addr = 1'b1;
          state_d    = SEL;
        end
      end
      SEL: begin
        // both strobes low is a protocol error: park here
        if (!cs_n_s && !rd_n_s && !wr_n_s) begin
          state_d = SEL;
        end else if (!cs_n_s && rd_fall) begin
          state_d = RD;
        end else if (!cs_n_s && wr_fall) begin
          state_d = WR;
        end else if (ale_rise) begin
          state_d = ADDR;
        end
      end
      RD: begin
        if (rd_rise || cs_rise) begin
          rd_exit = 1'b1;
          state_d = IDLE;
        end else if (!bus_ad_oe) begin
          rd_load = 1'b1;
        end
      end
      WR: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (wr_rise) begin
          wr_commit = ~cs_n_s;
          state_d   = IDLE;
        end else if (!wr_n_s) begin
          wr_cap = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n_s) begin
      state_d    = IDLE;
      latch_addr = 1'b0;
      rd_load    = 1'b0;
      rd_exit    = 1'b0;
      wr_cap     = 1'b0;
      wr_commit  = 1'b0;
    end
  end

  // only bits actually handed to the host get cleared
  assign ir_clr = (rd_exit && bus_ad_oe && addr_q == IR_A)
                ? bus_ad_o : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ad_o  <= 8'h00;
      bus_ad_oe <= 1'b0;
      bus_int_n <= 1'b1;
      wr_evt_o  <= 1'b0;
      wr_addr_o <= 8'h00;
      wr_data_o <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else if (!rst_n_s) begin
      bus_ad_o  <= 8'h00;
      bus_ad_oe <= 1'b0;
      bus_int_n <= 1'b1;
      wr_evt_o  <= 1'b0;
      wr_addr_o <= 8'h00;
      wr_data_o <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      wr_evt_o <= 1'b0;
      if (latch_addr) addr_q <= ad_s;
      if (wr_cap) wdata_q <= ad_s;
      if (rd_load) begin
        bus_ad_o  <= rdata;
        bus_ad_oe <= 1'b1;
      end
      if (rd_exit) bus_ad_oe <= 1'b0;
      if (wr_commit) begin
        wr_evt_o  <= 1'b1;
        wr_addr_o <= addr_q;
        wr_data_o <= wdata_q;
      end
      bus_int_n <= ~|(regs[IR_ADDR] & regs[IER_ADDR]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == 0) ? MODE_RST : 8'h00;
      end
    end else if (!rst_n_s) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == 0) ? MODE_RST : 8'h00;
      end
    end else begin
      if (wr_commit && in_range && addr_q != IR_A) begin
        regs[addr_q[ADDR_W-1:0]] <= wdata_q;
      end
      regs[IR_ADDR] <= (regs[IR_ADDR] & ~ir_clr) | evt_i;
    end
  end

endmodule

// File: tb/tb_can_bus_responder.sv
// Directed bench for can_bus_responder.
// Pin-level bus cycles, outputs sampled on the falling clock edge.
module tb_can_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_ad_i;
  logic [7:0] bus_ad_o;
  logic       bus_ad_oe;
  logic       bus_ale;
  logic       bus_cs_n;
  logic       bus_rd_n;
  logic       bus_wr_n;
  logic       bus_rst_n;
  logic       bus_int_n;
  logic [7:0] evt_i;
  logic       wr_evt_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [7:0] mode_o;

  int vectors = 0;
  int miscompares = 0;

  can_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus_ad_i  (bus_ad_i),
    .bus_ad_o  (bus_ad_o),
    .bus_ad_oe (bus_ad_oe),
    .bus_ale   (bus_ale),
    .bus_cs_n  (bus_cs_n),
    .bus_rd_n  (bus_rd_n),
    .bus_wr_n  (bus_wr_n),
    .bus_rst_n (bus_rst_n),
    .bus_int_n (bus_int_n),
    .evt_i     (evt_i),
    .wr_evt_o  (wr_evt_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .mode_o    (mode_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    bus_ale  = 1'b1;
    bus_ad_i = a;
    step(4);
    bus_ale = 1'b0;
    step(4);
  endtask

  task automatic bus_write(input logic [7:0] a,
                           input logic [7:0] d,
                           input string tag);
    int pulses;
    logic [7:0] wa;
    logic [7:0] wd;
    addr_phase(a);
    bus_cs_n = 1'b0;
    bus_wr_n = 1'b0;
    bus_ad_i = d;
    step(4);
    bus_wr_n = 1'b1;
    pulses = 0;
    wa = 8'h00;
    wd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (wr_evt_o) begin
        pulses++;
        wa = wr_addr_o;
        wd = wr_data_o;
      end
    end
    bus_cs_n = 1'b1;
    step(2);
    chk({tag, "_evt"}, 8'(pulses), 8'd1);
    chk({tag, "_waddr"}, wa, a);
    chk({tag, "_wdata"}, wd, d);
  endtask

  task automatic bus_read(input logic [7:0] a,
                          input logic [7:0] exp,
                          input string tag);
    addr_phase(a);
    bus_cs_n = 1'b0;
    bus_rd_n = 1'b0;
    step(3);
    chk({tag, "_oe_early"}, {7'd0, bus_ad_oe}, 8'd0);
    step(1);
    chk({tag, "_oe"}, {7'd0, bus_ad_oe}, 8'd1);
    chk({tag, "_data"}, bus_ad_o, exp);
    step(2);
    chk({tag, "_hold"}, bus_ad_o, exp);
    bus_rd_n = 1'b1;
    bus_cs_n = 1'b1;
    step(3);
    chk({tag, "_oe_off"}, {7'd0, bus_ad_oe}, 8'd0);
    step(2);
  endtask

  initial begin
    int pulses;
    int oe_seen;
    rst       = 1'b1;
    bus_ad_i  = 8'h00;
    bus_ale   = 1'b0;
    bus_cs_n  = 1'b1;
    bus_rd_n  = 1'b1;
    bus_wr_n  = 1'b1;
    bus_rst_n = 1'b1;
    evt_i     = 8'h00;
    step(3);
    chk("rst_oe", {7'd0, bus_ad_oe}, 8'd0);
    chk("rst_ad", bus_ad_o, 8'h00);
    chk("rst_int", {7'd0, bus_int_n}, 8'd1);
    chk("rst_evt", {7'd0, wr_evt_o}, 8'd0);
    chk("rst_waddr", wr_addr_o, 8'h00);
    chk("rst_wdata", wr_data_o, 8'h00);
    chk("rst_mode", mode_o, 8'h01);
    rst = 1'b0;
    step(4);

    bus_write(8'h10, 8'hA5, "wr10");
    bus_read(8'h10, 8'hA5, "rd10");
    bus_write(8'h00, 8'h33, "wr_mode");
    chk("mode33", mode_o, 8'h33);

    // interrupt raise and read-to-clear
    bus_write(8'h04, 8'h01, "ier01");
    evt_i = 8'h01;
    step(1);
    evt_i = 8'h00;
    step(1);
    chk("int_set", {7'd0, bus_int_n}, 8'd0);
    bus_read(8'h03, 8'h01, "rd_ir");
    chk("int_clr", {7'd0, bus_int_n}, 8'd1);
    bus_read(8'h03, 8'h00, "rd_ir0");

    // event landing in the clear cycle survives
    bus_write(8'h04, 8'h03, "ier03");
    evt_i = 8'h01;
    step(1);
    evt_i = 8'h00;
    step(2);
    chk("int_set2", {7'd0, bus_int_n}, 8'd0);
    addr_phase(8'h03);
    bus_cs_n = 1'b0;
    bus_rd_n = 1'b0;
    step(4);
    chk("irc_oe", {7'd0, bus_ad_oe}, 8'd1);
    chk("irc_data", bus_ad_o, 8'h01);
    bus_rd_n = 1'b1;
    bus_cs_n = 1'b1;
    step(2);
    evt_i = 8'h02;
    step(1);
    evt_i = 8'h00;
    chk("irc_oe_off", {7'd0, bus_ad_oe}, 8'd0);
    step(2);
    chk("irc_int", {7'd0, bus_int_n}, 8'd0);
    bus_read(8'h03, 8'h02, "rd_ir2");
    chk("irc_int_clr", {7'd0, bus_int_n}, 8'd1);

    // masked event keeps INT_n high
    bus_write(8'h04, 8'h01, "ier01b");
    evt_i = 8'h02;
    step(1);
    evt_i = 8'h00;
    step(3);
    chk("int_masked", {7'd0, bus_int_n}, 8'd1);
    bus_read(8'h03, 8'h02, "rd_ir3");

    // out-of-range address
    bus_read(8'h40, 8'hFF, "rd40");
    bus_write(8'h40, 8'h5A, "wr40");
    chk("mode_keep", mode_o, 8'h33);
    bus_read(8'h10, 8'hA5, "rd10b");

    // both strobes low: no drive, no commit
    addr_phase(8'h10);
    bus_cs_n = 1'b0;
    bus_rd_n = 1'b0;
    bus_wr_n = 1'b0;
    bus_ad_i = 8'h77;
    pulses = 0;
    oe_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (wr_evt_o) pulses++;
      if (bus_ad_oe) oe_seen++;
    end
    bus_rd_n = 1'b1;
    bus_wr_n = 1'b1;
    bus_cs_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (wr_evt_o) pulses++;
      if (bus_ad_oe) oe_seen++;
    end
    chk("perr_evt", 8'(pulses), 8'd0);
    chk("perr_oe", 8'(oe_seen), 8'd0);
    bus_read(8'h10, 8'hA5, "rd_after_perr");

    // host hardware reset pin
    bus_rst_n = 1'b0;
    step(4);
    chk("brst_mode", mode_o, 8'h01);
    bus_rst_n = 1'b1;
    step(4);
    bus_read(8'h10, 8'h00, "rd_after_brst");

    // async reset in the middle of a read
    bus_write(8'h10, 8'hC3, "wrC3");
    bus_write(8'h00, 8'h33, "wr_mode2");
    addr_phase(8'h10);
    bus_cs_n = 1'b0;
    bus_rd_n = 1'b0;
    step(5);
    chk("mid_oe", {7'd0, bus_ad_oe}, 8'd1);
    chk("mid_data", bus_ad_o, 8'hC3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_oe", {7'd0, bus_ad_oe}, 8'd0);
    chk("mid_rst_mode", mode_o, 8'h01);
    bus_rd_n = 1'b1;
    bus_cs_n = 1'b1;
    step(3);
    rst = 1'b0;
    step(4);
    bus_read(8'h10, 8'h00, "rd_after_rst");
    bus_write(8'h10, 8'h66, "wr66");
    bus_read(8'h10, 8'h66, "rd66");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
